// File: rtl/mux_scan_collector.sv
// -----------------------------------------------------------------------------
// mux_scan_collector
//
// Scan controller for a 16:1 bit multiplexer. It drives the mux select, steps
// it through every input index, samples the single-bit mux output once per
// index and packs the samples into a parallel word. The word is handed to a
// consumer over a valid/ready handshake. A scan is either single shot or
// repeats automatically after each accepted word.
//
// Parameters
//   N_IN   number of mux inputs scanned (= data_out width)
//   SEL_W  select width, 2**SEL_W must equal N_IN
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a scan (only honoured in IDLE)
//   cont_mode   1 = rescan after each accepted word, sampled at acceptance
//   abort       synchronous abort, overrides start and the handshake
//   mux_bit     mux output for the currently driven select
//   sel         registered select to the mux
//   busy        high while scanning or holding a word
//   data_out    assembled word, bit k sampled with sel == k
//   data_valid  word available
//   data_ready  consumer accepts the word
//   changed     with data_valid: data_out differs from the last accepted word
// -----------------------------------------------------------------------------
module mux_scan_collector #(
  parameter int N_IN  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             abort,
  input  logic             mux_bit,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_IN-1:0]  data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             changed
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  state_t            state;
  logic [N_IN-1:0]   capture;    // samples collected so far in this scan
  logic [N_IN-1:0]   prev_word;  // last word the consumer accepted
  logic [N_IN-1:0]   word_next;  // completed word on the final sample edge

  // The last sample never lands in capture; it is merged straight into the
  // delivered word so the word is ready right after the 16th sample edge.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    word_next           = capture;
    word_next[N_IN-1]   = mux_bit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      changed    <= 1'b0;
      capture    <= '0;
      prev_word  <= '0;
    end else if (abort) begin
      // Partial scan is dropped; data_out and prev_word keep their contents
      // so the change detector still compares against the last real word.
      state      <= IDLE;
      sel        <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      capture    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            capture <= '0;
          end
        end

        SCAN: begin
          capture[sel] <= mux_bit;
          if (sel == SEL_LAST) begin
            data_out   <= word_next;
            changed    <= (word_next != prev_word);
            data_valid <= 1'b1;
            sel        <= '0;
            state      <= HOLD;
          end else begin
            sel <= sel + 1'b1;
          end
        end

        HOLD: begin
          sel <= '0;
          if (data_valid && data_ready) begin
            prev_word  <= data_out;
            data_valid <= 1'b0;
            if (cont_mode) begin
              // First sample of the next scan is taken on the following edge.
              state   <= SCAN;
              capture <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_collector.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_collector
//
// Bench for mux_scan_collector. A behavioural 16:1 mux (mux_bit = pattern[sel])
// sits in front of the DUT. Directed sequences cover reset, single scans from a
// table, backpressure, continuous mode, abort, ignored start and mid-scan
// reset; a randomized phase checks transactions against a word-level model
// (expected word = the pattern presented, changed = differs from the last
// accepted word, latency = 16 edges after start or acceptance).
// -----------------------------------------------------------------------------
module tb_mux_scan_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont_mode;
  logic        abort;
  logic        mux_bit;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        changed;

  logic [15:0] pattern;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] pattern;
    logic [15:0] exp_word;
    logic        exp_changed;
  } vec_t;

  vec_t vecs[7];

  mux_scan_collector #(
    .N_IN (16),
    .SEL_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont_mode (cont_mode),
    .abort     (abort),
    .mux_bit   (mux_bit),
    .sel       (sel),
    .busy      (busy),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .changed   (changed)
  );

  // Behavioural mux in front of the collector.
  assign mux_bit = pattern[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle to a point away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a scan of pat and run to the edge that delivers the word, checking
  // the select sequence. glitch_at >= 0 pulses start while sel == glitch_at.
  task automatic scan_to_valid(input logic [15:0] pat, input int glitch_at);
    pattern = pat;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("scan_start_busy", 32'(busy), 32'd1);
    check("scan_start_sel", 32'(sel), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == glitch_at + 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (i < 16) begin
        check("scan_sel_step", 32'(sel), 32'(i));
        check("scan_valid_low", 32'(data_valid), 32'd0);
        check("scan_busy", 32'(busy), 32'd1);
      end else begin
        check("scan_valid_high", 32'(data_valid), 32'd1);
        check("scan_sel_wrap", 32'(sel), 32'd0);
      end
    end
  endtask

  task automatic accept_word(input logic exp_busy);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("accept_valid_low", 32'(data_valid), 32'd0);
    check("accept_busy", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    int          cyc;
    int          nw;
    int          t_word[3];
    logic [15:0] w_word[3];
    logic        c_word[3];
    logic        saw_valid;
    logic [15:0] model_prev;
    logic [15:0] cur;
    logic [15:0] nxt;
    logic        chained;
    logic        cont;
    logic        exp_ch;
    int          dly;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{16'hA5C3, 16'hA5C3, 1'b1};
    vecs[2] = '{16'hA5C3, 16'hA5C3, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8001, 16'h8001, 1'b1};
    vecs[5] = '{16'h8001, 16'h8001, 1'b0};
    vecs[6] = '{16'h7FFE, 16'h7FFE, 1'b1};

    rst_n      = 1'b0;
    start      = 1'b0;
    cont_mode  = 1'b0;
    abort      = 1'b0;
    data_ready = 1'b0;
    pattern    = 16'h0000;

    // ---- reset held with start toggling ----
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
    end
    start = 1'b0;
    #3 rst_n = 1'b1;  // release mid-cycle
    data_ready = 1'b1;  // ready with no valid word must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle_busy", 32'(busy), 32'd0);
      check("post_rst_idle_valid", 32'(data_valid), 32'd0);
    end
    data_ready = 1'b0;

    // ---- table-driven single scans ----
    for (int v = 0; v < 7; v++) begin
      scan_to_valid(vecs[v].pattern, -1);
      check("tbl_word", 32'(data_out), 32'(vecs[v].exp_word));
      check("tbl_changed", 32'(changed), 32'(vecs[v].exp_changed));
      accept_word(1'b0);
    end

    // ---- backpressure ----
    scan_to_valid(16'hA5C3, -1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", 32'(data_out), 32'h0000A5C3);
      check("bp_valid", 32'(data_valid), 32'd1);
      check("bp_sel", 32'(sel), 32'd0);
    end
    check("bp_changed", 32'(changed), 32'd1);
    accept_word(1'b0);
    tick();
    tick();
    check("bp_single_accept", 32'(data_valid), 32'd0);

    // ---- continuous mode ----
    pattern    = 16'h1234;
    cont_mode  = 1'b1;
    data_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    nw    = 0;
    while (nw < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (data_valid === 1'b1) begin
        t_word[nw] = cyc;
        w_word[nw] = data_out;
        c_word[nw] = changed;
        nw++;
        if (nw == 2) pattern = 16'hFFFF;
        if (nw == 3) cont_mode = 1'b0;
      end
    end
    check("cont_words", 32'(nw), 32'd3);
    check("cont_t0", 32'(t_word[0]), 32'd16);
    check("cont_t1", 32'(t_word[1]), 32'd33);
    check("cont_t2", 32'(t_word[2]), 32'd50);
    check("cont_w0", 32'(w_word[0]), 32'h00001234);
    check("cont_w1", 32'(w_word[1]), 32'h00001234);
    check("cont_w2", 32'(w_word[2]), 32'h0000FFFF);
    check("cont_c0", 32'(c_word[0]), 32'd1);
    check("cont_c1", 32'(c_word[1]), 32'd0);
    check("cont_c2", 32'(c_word[2]), 32'd1);
    tick();
    data_ready = 1'b0;
    check("cont_end_valid", 32'(data_valid), 32'd0);
    check("cont_end_busy", 32'(busy), 32'd0);

    // ---- abort mid-scan ----
    pattern = 16'h5A5A;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("abort_pre_sel", 32'(sel), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_data_kept", 32'(data_out), 32'h0000FFFF);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    check("abort_no_word", 32'(saw_valid), 32'd0);
    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    tick();
    check("abort_start_stay", 32'(busy), 32'd0);
    scan_to_valid(16'h5A5A, -1);
    check("abort_rescan_word", 32'(data_out), 32'h00005A5A);
    check("abort_rescan_changed", 32'(changed), 32'd1);
    accept_word(1'b0);

    // ---- start during a scan is ignored ----
    scan_to_valid(16'h0F0F, 3);
    check("glitch_word", 32'(data_out), 32'h00000F0F);
    check("glitch_changed", 32'(changed), 32'd1);
    accept_word(1'b0);
    tick();
    check("glitch_not_queued", 32'(busy), 32'd0);

    // ---- asynchronous reset mid-scan ----
    scan_to_valid(16'h3C3C, -1);
    accept_word(1'b0);
    pattern = 16'hC3C3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("arst_pre_sel", 32'(sel), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_changed", 32'(changed), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    #3 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    check("arst_no_word", 32'(saw_valid), 32'd0);

    // ---- randomized transactions against the word-level model ----
    model_prev = 16'h0000;
    chained    = 1'b0;
    cur        = 16'($urandom);
    for (int t = 0; t < 12; t++) begin
      pattern = cur;
      if (!chained) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      cyc = 0;
      while (data_valid !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      exp_ch = (cur != model_prev);
      check("rnd_latency", 32'(cyc), 32'd16);
      check("rnd_word", 32'(data_out), 32'(cur));
      check("rnd_changed", 32'(changed), 32'(exp_ch));
      dly = int'($urandom_range(0, 3));
      for (int i = 0; i < dly; i++) tick();
      check("rnd_hold", 32'({data_valid, data_out}), 32'({1'b1, cur}));
      nxt        = ($urandom_range(0, 3) == 0) ? cur : 16'($urandom);
      cont       = 1'($urandom_range(0, 1));
      cont_mode  = cont;
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      model_prev = cur;
      check("rnd_accept_valid", 32'(data_valid), 32'd0);
      check("rnd_accept_busy", 32'(busy), 32'(cont));
      chained = cont;
      cur     = nxt;
    end
    if (chained) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    cont_mode = 1'b0;
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_collector.md
Name: mux_scan_collector

Overview:
- Sequential scan controller that sits directly downstream of, and drives the select of, the 16:1 bit multiplexer (mux_4_to_16).
- Steps the select through every input index.
- Samples the mux's single-bit output once per index and assembles the 16 samples into a parallel word.
- Delivers the word over a valid/ready handshake, in single-shot or continuous mode.

Parameters:
- N_IN, 16, number of mux inputs scanned; equals the output word width.
- SEL_W, 4, select width; must satisfy 2**SEL_W == N_IN.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- cont_mode  input  1  1 = rescan automatically after each handshake; 0 = single shot. Sampled when a word is accepted.
- abort  input  1  synchronous abort; has priority over start and the handshake.
- mux_bit  input  1  mux output (fin) for the currently driven select.
- sel  output  SEL_W  registered select driven to the mux.
- busy  output  1  high in SCAN and HOLD.
- data_out  output  N_IN  assembled word; bit k is the sample taken with sel==k.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts the word.
- changed  output  1  qualified by data_valid; high when data_out differs from the previously delivered word.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, sel=0, busy=0, data_valid=0, changed=0;
  - data_out=0, internal shift/capture register=0, previous-word register=0.
- Release of reset is synchronous to clk.
- The mux is combinational. sel is a register output, so mux_bit is valid for the current sel and is sampled at the next rising edge.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - sel=0, busy=0.
  - start=1 (and abort=0) at an edge moves to SCAN, with sel=0 and the capture register cleared.
- SCAN:
  - Each edge writes capture[sel] <= mux_bit and sel <= sel+1.
  - At the edge where sel==N_IN-1:
    - data_out <= capture with bit N_IN-1 = mux_bit;
    - changed <= (that word != previous-word register);
    - data_valid <= 1;
    - sel wraps to 0;
    - state moves to HOLD.
- Latency: with start seen at edge 0, the first sample is at edge 1, the last sample is at edge 16, and data_valid is high after edge 16. That is 16 cycles in SCAN and no idle cycles inside a scan.
- HOLD:
  - data_out, changed and data_valid are held stable; sel is held at 0.
  - An edge with data_valid & data_ready:
    - previous-word register <= data_out;
    - data_valid <= 0;
    - next state is SCAN if cont_mode=1, otherwise IDLE.
  - In continuous mode the next scan's first sample is taken on the edge after acceptance.
  - data_valid is never withdrawn without a handshake, except by abort or reset.
- abort=1 at an edge, in any state:
  - next state IDLE, sel=0, data_valid=0, capture cleared;
  - data_out and the previous-word register keep their values;
  - a partial scan is discarded and never delivered.
- start while in SCAN or HOLD is ignored; it is not queued.
- start and abort asserted together in IDLE: abort wins and the block stays in IDLE.
- data_ready while data_valid=0 is ignored.
- changed for the first word after reset compares against 0, so an all-zero first word gives changed=0.
- Reset mid-scan or mid-HOLD: the outputs take their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold rst_n=0 with start=1 toggling -> sel=0, busy=0, data_valid=0, data_out=0. Deassert rst_n mid-cycle -> no activity until a start is seen at an edge.
- Single scan: model the mux with pattern 0xA5C3 (mux_bit = pattern[sel]); pulse start at edge 0 ->
  - sel steps 0..15 on edges 1..16;
  - data_valid=1 after edge 16 with data_out=0xA5C3 and changed=1;
  - with data_ready=1 -> IDLE and busy=0 on the next edge.
- Backpressure: hold data_ready=0 for 5 cycles in HOLD -> data_out stays 0xA5C3, data_valid stays 1, sel stays 0. Raise data_ready -> exactly one accept.
- Continuous mode, with cont_mode=1 and data_ready tied high:
  - patterns 0x1234 then 0x1234 then 0xFFFF -> three words delivered back-to-back, 17 cycles apart;
  - changed = 1, 0, 1 for the three words.
- Abort mid-scan: assert abort when sel==7 -> IDLE next edge, sel=0, data_valid never asserted, data_out keeps the prior value. A new start yields the correct full word.
- Ignored start and async reset: a start pulse at sel==3 has no effect, and the word completes on schedule. Then pulse rst_n low at sel==9 -> all outputs return to reset values immediately and no word is delivered.
